div_unit: RTL and testbench



---
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient} and becomes valid with a one-cycle ready pulse.
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_signed_div,
  input  logic [31:0] i_opdata1,
  input  logic [31:0] i_opdata2,
  input  logic        i_annul,
  output logic        o_busy,
  output logic        o_ready,
  output logic [63:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_neg_quot;
  logic        r_neg_rem;
  logic [63:0] r_result;
  logic        r_busy;
  logic        r_ready;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [64:0] w_shifted;
  logic [32:0] w_diff;
  logic [64:0] w_next_work;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // 0x80000000 negates to itself, which is exactly its magnitude read as unsigned.
  assign w_abs1 = (i_signed_div && i_opdata1[31]) ? (32'd0 - i_opdata1) : i_opdata1;
  assign w_abs2 = (i_signed_div && i_opdata2[31]) ? (32'd0 - i_opdata2) : i_opdata2;

  // Bit 32 of the 33-bit difference is set exactly when the trial subtraction underflows.
  assign w_shifted   = {r_work[63:0], 1'b0};
  assign w_diff      = w_shifted[64:32] - {1'b0, r_divisor};
  assign w_next_work = w_diff[32] ? w_shifted : {w_diff, w_shifted[31:1], 1'b1};
  assign w_quot      = w_next_work[31:0];
  assign w_rem       = w_next_work[63:32];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_work     <= 65'd0;
      r_divisor  <= 32'd0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= 64'd0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_annul) begin
            r_busy <= 1'b1;
            if (i_opdata2 == 32'd0) begin
              r_state <= S_DIVZERO;
            end else begin
              r_state    <= S_ON;
              r_cnt      <= 5'd0;
              r_work     <= {33'd0, w_abs1};
              r_divisor  <= w_abs2;
              r_neg_quot <= i_signed_div & (i_opdata1[31] ^ i_opdata2[31]);
              r_neg_rem  <= i_signed_div & i_opdata1[31];
            end
          end
        end
        S_DIVZERO: begin
          r_busy <= 1'b0;
          if (i_annul) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_END;
            r_result <= 64'd0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (i_annul) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_work <= w_next_work;
            r_cnt  <= r_cnt + 5'd1;
            // The final iteration's value is taken straight from the datapath.
            if (r_cnt == 5'd31) begin
              r_state  <= S_END;
              r_busy   <= 1'b0;
              r_ready  <= 1'b1;
              r_result <= {(r_neg_rem  ? (32'd0 - w_rem)  : w_rem),
                           (r_neg_quot ? (32'd0 - w_quot) : w_quot)};
            end
          end
        end
        S_END: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_ready  = r_ready;
  assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, annul/reset/start-blocking
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signedDiv;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int          checks;
  int          failures;
  logic [63:0] lastResult;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  div_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_signed_div (signedDiv),
    .i_opdata1    (op1),
    .i_opdata2    (op2),
    .i_annul      (annul),
    .o_busy       (busy),
    .o_ready      (ready),
    .o_result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like DIV.
  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Issues one request and follows it to ready, checking latency, busy length and result.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expResult, input bit pokeStart, input string tag);
    int cycles;
    int busyCnt;
    int expLatency;
    int expBusy;
    expLatency = (b == 32'd0) ? 2 : 33;
    expBusy    = (b == 32'd0) ? 1 : 32;
    @(negedge clk);
    start = 1'b1;
    signedDiv = s;
    op1 = a;
    op2 = b;
    checkOutput({tag, " accept-cycle busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    signedDiv = 1'($urandom_range(0, 1));
    cycles = 1;
    busyCnt = 0;
    while (!ready && cycles < 100) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cycles++;
      start = pokeStart && (cycles == 5 || cycles == 20);
    end
    start = 1'b0;
    checkOutput({tag, " ready seen"}, 64'(ready), 64'd1);
    checkOutput({tag, " latency"}, 64'(cycles), 64'(expLatency));
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(expBusy));
    checkOutput({tag, " busy at ready"}, 64'(busy), 64'd0);
    checkOutput({tag, " result"}, result, expResult);
    if (ready) lastResult = expResult;
    @(negedge clk);
    checkOutput({tag, " ready pulse width"}, 64'(ready), 64'd0);
    checkOutput({tag, " result held"}, result, lastResult);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cycles;
    int readySeen;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    checks = 0;
    failures = 0;
    lastResult = 64'd0;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'd2,        {32'h00000001, 32'h7FFFFFFF}};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    vecs[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}};
    vecs[5] = '{1'b0, 32'd123,      32'd0,        64'd0};
    vecs[6] = '{1'b0, 32'd100,      32'd3,        {32'd1, 32'd33}};
    vecs[7] = '{1'b1, 32'd10,       32'd5,        {32'd0, 32'd2}};

    rst = 1'b1;
    start = 1'b0;
    signedDiv = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    annul = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset result", result, 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Annul in flight: back to idle, no ready, previous result kept.
    @(negedge clk);
    start = 1'b1;
    signedDiv = 1'b0;
    op1 = 32'd100;
    op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    checkOutput("annul busy", 64'(busy), 64'd0);
    checkOutput("annul ready", 64'(ready), 64'd0);
    checkOutput("annul result", result, lastResult);
    readySeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) readySeen++;
    end
    checkOutput("annul no ready", 64'(readySeen), 64'd0);
    checkOutput("annul result kept", result, lastResult);

    applyStimulus(1'b0, 32'd100, 32'd3, {32'd1, 32'd33}, 1'b1, "restart with pokes");

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1;
    signedDiv = 1'b0;
    op1 = 32'd100;
    op2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset ready", 64'(ready), 64'd0);
    checkOutput("midreset result", result, 64'd0);
    lastResult = 64'd0;
    applyStimulus(1'b0, 32'd10, 32'd5, {32'd0, 32'd2}, 1'b0, "after reset");

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h80000000;
      endcase
      if (i % 8 == 3) a = 32'h80000000;
      applyStimulus(s, a, b, refDiv(s, a, b), 1'b0, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
